// File: rtl/motoro3_pkg.sv
// Shared types and helpers for the motoro3 gate-pattern monitor.
// Gate bus bit order everywhere: {aH, aL, bH, bL, cH, cL}.
package motoro3_pkg;

  // Six-step commutation patterns, indexed by step number.
  localparam logic [5:0][5:0] STEP_PAT = {
    6'b00_01_10,  // 5: cH, bL
    6'b01_00_10,  // 4: cH, aL
    6'b01_10_00,  // 3: bH, aL
    6'b00_10_01,  // 2: bH, cL
    6'b10_00_01,  // 1: aH, cL
    6'b10_01_00   // 0: aH, bL
  };

  typedef enum logic [2:0] {
    PC_STEP,
    PC_OFF,
    PC_HALF,
    PC_SHOOT,
    PC_ILLEGAL
  } pat_class_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_GAP
  } state_e;

  function automatic logic [2:0] step_next(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] step_prev(input logic [2:0] s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

endpackage

// File: rtl/motoro3_patdec.sv
// Combinational classifier: registered gate pattern -> pattern class and step.
module motoro3_patdec
  import motoro3_pkg::*;
(
  input  logic [5:0] pat,
  output pat_class_e pat_class,
  output logic [2:0] pat_step
);

  logic shoot;
  assign shoot = (pat[5] & pat[4]) | (pat[3] & pat[2]) | (pat[1] & pat[0]);

  // Classify; shoot-through outranks everything, then off/half, then step match.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    pat_class = PC_ILLEGAL;
    pat_step  = 3'd0;
    if (shoot) begin
      pat_class = PC_SHOOT;
    end else if (pat == 6'b0) begin
      pat_class = PC_OFF;
    end else if ((pat & (pat - 6'd1)) == 6'b0) begin
      pat_class = PC_HALF;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (pat == STEP_PAT[i]) begin
          pat_class = PC_STEP;
          pat_step  = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/motoro3_gate_mon.sv
// Gate-pattern monitor: recovers step, direction and step period from the six
// gate lines, and raises sticky faults for shoot-through, illegal patterns,
// skipped steps and stalls.
module motoro3_gate_mon
  import motoro3_pkg::*;
#(
  parameter int PW       = 20,
  parameter int DEAD_MAX = 16
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          aH,
  input  logic          aL,
  input  logic          bH,
  input  logic          bL,
  input  logic          cH,
  input  logic          cL,
  input  logic          fltClr,
  output logic [2:0]    stepIdx,
  output logic          stepVld,
  output logic          dir,
  output logic          dirVld,
  output logic [PW-1:0] period,
  output logic          periodVld,
  output logic          running,
  output logic          fltShoot,
  output logic          fltIllegal,
  output logic          fltSkip,
  output logic          fltStall
);

  localparam int            GW      = $clog2(DEAD_MAX + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(DEAD_MAX);
  localparam logic [PW-1:0] CNT_MAX = '1;

  logic [5:0]    pat_reg;
  pat_class_e    pat_class;
  logic [2:0]    pat_step;
  state_e        state, state_nxt;
  logic [PW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic          have_dir;  // previous entry was adjacent, so dir can be compared

  logic is_step, new_step, is_fwd, is_rev, adjacent;
  logic start_run, entry, cnt_inc, gap_start, gap_inc;
  logic set_shoot, set_illegal, set_stall;

  motoro3_patdec u_patdec (
    .pat       (pat_reg),
    .pat_class (pat_class),
    .pat_step  (pat_step)
  );

  assign is_step  = (pat_class == PC_STEP);
  assign new_step = (pat_step != stepIdx);
  assign is_fwd   = (pat_step == step_next(stepIdx));
  assign is_rev   = (pat_step == step_prev(stepIdx));
  assign adjacent = is_fwd | is_rev;

  // Single input register; all decoding looks at pat_reg only.
  always_ff @(posedge clk or negedge nRst) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!nRst) pat_reg <= 6'b0;
    else       pat_reg <= {aH, aL, bH, bL, cH, cL};
  end

  // State register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the event strobes that steer counters and flags.
  always_comb begin
    state_nxt   = state;
    start_run   = 1'b0;
    entry       = 1'b0;
    cnt_inc     = 1'b0;
    gap_start   = 1'b0;
    gap_inc     = 1'b0;
    set_shoot   = 1'b0;
    set_illegal = 1'b0;
    set_stall   = 1'b0;
    if (pat_class == PC_SHOOT) begin
      set_shoot = 1'b1;
      state_nxt = ST_IDLE;
    end else if (pat_class == PC_ILLEGAL) begin
      set_illegal = 1'b1;
      state_nxt   = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (is_step) begin
            start_run = 1'b1;
            state_nxt = ST_STEP;
          end
        end
        ST_STEP: begin
          if (is_step && new_step) begin
            entry = 1'b1;
          end else if (cnt == CNT_MAX) begin
            set_stall = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            cnt_inc = 1'b1;
            if (!is_step) begin
              gap_start = 1'b1;
              state_nxt = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (is_step && new_step) begin
            entry     = 1'b1;
            state_nxt = ST_STEP;
          end else if (!is_step && gap_cnt >= GAP_MAX) begin
            // A long all-off gap is a normal stop; a lingering single line is not.
            set_illegal = (pat_class == PC_HALF);
            state_nxt   = ST_IDLE;
          end else if (cnt == CNT_MAX) begin
            set_stall = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            cnt_inc = 1'b1;
            if (is_step) state_nxt = ST_STEP;
            else         gap_inc   = 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    stepVld = (state != ST_IDLE);
    running = (state != ST_IDLE);
  end

  // Step index, direction, period measurement and gap counting.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      stepIdx   <= 3'd0;
      dir       <= 1'b0;
      dirVld    <= 1'b0;
      have_dir  <= 1'b0;
      period    <= '0;
      periodVld <= 1'b0;
      cnt       <= '0;
      gap_cnt   <= '0;
    end else begin
      periodVld <= 1'b0;
      if (start_run) begin
        stepIdx  <= pat_step;
        cnt      <= PW'(1);
        dirVld   <= 1'b0;
        have_dir <= 1'b0;
      end else if (entry) begin
        stepIdx <= pat_step;
        cnt     <= PW'(1);
        if (adjacent) begin
          dir       <= is_fwd;
          dirVld    <= have_dir && (dir == is_fwd);
          have_dir  <= 1'b1;
          period    <= cnt;
          periodVld <= 1'b1;
        end else begin
          dirVld   <= 1'b0;
          have_dir <= 1'b0;
        end
      end else if (cnt_inc) begin
        cnt <= cnt + PW'(1);
      end

      if (gap_start)    gap_cnt <= GW'(1);
      else if (gap_inc) gap_cnt <= gap_cnt + GW'(1);

      if (state_nxt == ST_IDLE) begin
        dirVld   <= 1'b0;
        have_dir <= 1'b0;
      end
    end
  end

  // Sticky faults; a fault detected together with fltClr is kept.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      fltShoot   <= 1'b0;
      fltIllegal <= 1'b0;
      fltSkip    <= 1'b0;
      fltStall   <= 1'b0;
    end else begin
      fltShoot   <= (fltShoot   & ~fltClr) | set_shoot;
      fltIllegal <= (fltIllegal & ~fltClr) | set_illegal;
      fltSkip    <= (fltSkip    & ~fltClr) | (entry & ~adjacent);
      fltStall   <= (fltStall   & ~fltClr) | set_stall;
    end
  end

endmodule
